// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state type and reset constants for the pipeline sequencer
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN, WAIT, ABORT} state_t;
  localparam int unsigned CNT_RST = 0;
  localparam logic MEMERR_RST = 1'b0;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard requests, memory handshake, stage strobes and counters
interface pipeline_ctrl_if #(parameter int CNT_WIDTH = 32);
  logic StallFH, StallDH, FlushDH, FlushEH, MemOpM, MemReady;
  logic MemValid, EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrW, MemErr;
  logic [CNT_WIDTH-1:0] StallCycles, FlushCount;
  modport master (
    output StallFH, StallDH, FlushDH, FlushEH, MemOpM, MemReady,
    input  MemValid, EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrW, MemErr, StallCycles, FlushCount
  );
  modport slave (
    input  StallFH, StallDH, FlushDH, FlushEH, MemOpM, MemReady,
    output MemValid, EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrW, MemErr, StallCycles, FlushCount
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones, cleared asynchronously
module sat_counter import pipeline_ctrl_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;
  // count events, holding once every bit is set
  always_ff @(posedge clk or posedge i_clear)
    if (i_clear) r_count <= WIDTH'(CNT_RST);
    else if (i_inc && !(&r_count)) r_count <= r_count + 1'b1;
  assign o_count = r_count;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: merges hazard requests with the M-stage memory handshake into stage strobes
module pipeline_ctrl import pipeline_ctrl_pkg::*; #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t               r_state;
  logic [WW-1:0]        r_wcnt;
  logic                 r_err;
  logic                 w_mv, w_freeze, w_abort;
  logic [CNT_WIDTH-1:0] w_stall, w_flush;
  assign w_abort  = r_state == ABORT;
  assign w_mv     = !rst && (r_state == WAIT || (r_state == RUN && bus.MemOpM));
  assign w_freeze = w_mv && !bus.MemReady;
  // stage strobes: reset forces bubbles, a freeze masks hazards, abort flushes M out through W
  always_comb begin
    bus.MemValid = w_mv;
    bus.EnF      = !rst && (w_abort || (!w_freeze && !bus.StallFH));
    bus.EnD      = !rst && (w_abort || (!w_freeze && !bus.StallDH));
    bus.EnE      = !rst && !w_freeze;
    bus.EnM      = !rst && !w_freeze;
    bus.EnW      = !rst;
    bus.ClrD     = rst || (!w_freeze && bus.FlushDH);
    bus.ClrE     = rst || (!w_freeze && bus.FlushEH);
    bus.ClrW     = rst || w_freeze || w_abort;
  end
  // access sequencer: wait for MemReady, abort after TIMEOUT wait cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= RUN;
      r_wcnt  <= '0;
      r_err   <= MEMERR_RST;
    end else case (r_state)
      RUN:
        if (bus.MemOpM && !bus.MemReady) begin
          r_state <= WAIT;
          r_wcnt  <= WW'(1);
        end
      WAIT:
        if (bus.MemReady) r_state <= RUN;
        else if (r_wcnt == WW'(TIMEOUT)) begin
          r_state <= ABORT;
          r_err   <= 1'b1;
        end else r_wcnt <= r_wcnt + 1'b1;
      default: r_state <= RUN;
    endcase
  assign bus.MemErr = r_err;
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall (
    .clk(clk), .i_clear(rst), .i_inc(!bus.EnF && !rst), .o_count(w_stall)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush (
    .clk(clk), .i_clear(rst), .i_inc(bus.ClrD && !rst), .o_count(w_flush)
  );
  assign bus.StallCycles = w_stall;
  assign bus.FlushCount  = w_flush;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed test-plan scenarios plus random traffic against a behavioural model
module tb_pipeline_ctrl;
  localparam int TO = 4;
  localparam int CW = 8;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_age = 0;
  bit m_abort = 0;
  bit m_err = 0;
  int m_stall = 0;
  int m_flush = 0;
  pipeline_ctrl_if #(.CNT_WIDTH(CW)) b ();
  pipeline_ctrl #(.TIMEOUT(TO), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ctl", {b.MemValid, b.EnF, b.EnD, b.EnE, b.EnM, b.EnW, b.ClrD, b.ClrE, b.ClrW}, 9'b0_00000_111);
    chk("rst_err", b.MemErr, 0);
    chk("rst_stall", b.StallCycles, 0);
    chk("rst_flush", b.FlushCount, 0);
    m_age = 0; m_abort = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask
  task automatic cyc(input bit sfh, input bit sdh, input bit fdh, input bit feh, input bit op, input bit rdy);
    bit mv, frz, ef, ed, ee, cd, ce, cw;
    @(negedge clk);
    rst = 1'b0;
    b.StallFH = sfh; b.StallDH = sdh; b.FlushDH = fdh; b.FlushEH = feh; b.MemOpM = op; b.MemReady = rdy;
    #1;
    mv  = m_abort ? 1'b0 : (m_age > 0) ? 1'b1 : op;
    frz = mv && !rdy;
    ef  = m_abort || (!frz && !sfh);
    ed  = m_abort || (!frz && !sdh);
    ee  = !frz;
    cd  = !frz && fdh;
    ce  = !frz && feh;
    cw  = frz || m_abort;
    chk("ctl", {b.MemValid, b.EnF, b.EnD, b.EnE, b.EnM, b.EnW, b.ClrD, b.ClrE, b.ClrW},
        {mv, ef, ed, ee, ee, 1'b1, cd, ce, cw});
    chk("err", b.MemErr, m_err);
    chk("stall", b.StallCycles, m_stall);
    chk("flush", b.FlushCount, m_flush);
    if (!ef && m_stall < MAXC) m_stall++;
    if (cd && m_flush < MAXC) m_flush++;
    if (m_abort) m_abort = 0;
    else if (m_age > 0) begin
      if (rdy) m_age = 0;
      else if (m_age == TO) begin m_abort = 1; m_err = 1; m_age = 0; end
      else m_age++;
    end else if (op && !rdy) m_age = 1;
  endtask
  initial begin
    b.StallFH = 0; b.StallDH = 0; b.FlushDH = 0; b.FlushEH = 0; b.MemOpM = 0; b.MemReady = 0;
    do_reset();
    cyc(0, 0, 0, 0, 1, 1);
    chk("zw_mv", b.MemValid, 1);
    chk("zw_en", {b.EnF, b.EnD, b.EnE, b.EnM, b.EnW}, 5'b11111);
    cyc(0, 0, 0, 0, 0, 0);
    chk("zw_stall", b.StallCycles, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk("w3_frz", {b.EnF, b.EnD, b.EnE, b.EnM, b.ClrW}, 5'b00001);
    end
    cyc(0, 0, 0, 0, 1, 1);
    chk("w3_rel", {b.EnF, b.EnD, b.EnE, b.EnM, b.ClrW}, 5'b11110);
    cyc(0, 0, 0, 0, 0, 0);
    chk("w3_stall", b.StallCycles, 3);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 1, 1, 0);
      chk("fl_mask", {b.ClrD, b.ClrE}, 2'b00);
    end
    cyc(0, 0, 1, 1, 1, 1);
    chk("fl_rel", {b.ClrD, b.ClrE}, 2'b11);
    cyc(0, 0, 0, 0, 0, 0);
    chk("fl_cnt", b.FlushCount, 1);
    do_reset();
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TO; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("ab_out", {b.MemValid, b.ClrW, b.EnM}, 3'b011);
    chk("ab_err", b.MemErr, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("ab_sticky", b.MemErr, 1);
    do_reset();
    for (int i = 0; i < MAXC + 5; i++) cyc(1, 1, 0, 0, 0, 0);
    chk("st_en", {b.EnF, b.EnD, b.EnE}, 3'b001);
    chk("st_sat", b.StallCycles, MAXC);
    do_reset();
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    chk("rw_run", b.MemValid, 0);
    chk("rw_cnt", {b.MemErr, b.StallCycles, b.FlushCount}, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      cyc($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0,
          $urandom_range(9) < 4, $urandom_range(9) < 3);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequencer for the five-stage pipeline registers. It merges stall/flush requests from the hazard unit with a variable-latency data-memory handshake in the M stage. It produces per-stage enable and clear strobes, freezes the pipeline while a memory access is outstanding, and aborts accesses that time out. It sits between the hazard unit and the F/D/E/M/W pipeline registers, and also keeps saturating stall and flush performance counters.

## Interface
- TIMEOUT, 16: maximum WAIT cycles before a memory access is aborted; must be ≥2.
- CNT_WIDTH, 32: width of the performance counters.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- StallFH  in  1  fetch stall request from the hazard unit.
- StallDH  in  1  decode stall request from the hazard unit.
- FlushDH  in  1  decode flush request from the hazard unit.
- FlushEH  in  1  execute flush request from the hazard unit.
- MemOpM  in  1  instruction in M is a load or store.
- MemReady  in  1  data memory has completed the current access.
- MemValid  out  1  access request to data memory.
- EnF, EnD, EnE, EnM, EnW  out  1 each  pipeline-register load enables.
- ClrD, ClrE, ClrW  out  1 each  synchronous bubble insert into the D, E and W registers.
- MemErr  out  1  sticky flag; set by a timeout abort.
- StallCycles  out  CNT_WIDTH  count of cycles in which the front end did not advance.
- FlushCount  out  CNT_WIDTH  count of applied decode flushes.

## Operation
- States are RUN, WAIT and ABORT. Reset places the FSM in RUN with the wait counter at 0, MemErr at 0 and both performance counters at 0.
- While rst is high, all outputs are forced as follows: MemValid=0, all En=0, ClrD=ClrE=ClrW=1.
- MemValid is MemOpM in RUN, 1 in WAIT, and 0 in ABORT.
- freeze = MemValid & !MemReady.
- When freeze is high:
  - EnF=EnD=EnE=EnM=0.
  - ClrD=ClrE=0; hazard requests are masked.
  - EnW=1 and ClrW=1, so W receives a bubble and no register write is repeated.
- When freeze is low (RUN or WAIT):
  - EnF=!StallFH, EnD=!StallDH.
  - EnE=EnM=EnW=1.
  - ClrD=FlushDH, ClrE=FlushEH, ClrW=0.
- When in ABORT:
  - All En=1 and ClrW=1, which kills the aborted instruction as it leaves M.
  - ClrD=FlushDH, ClrE=FlushEH.
- RUN transitions:
  - To WAIT if MemOpM & !MemReady; the wait counter loads 1.
  - Otherwise the FSM stays in RUN. This includes a zero-wait access, where MemReady arrives in the same cycle as the request.
- WAIT transitions:
  - If MemReady: go to RUN. The pipeline advances in this same cycle.
  - Else, if the wait counter equals TIMEOUT: go to ABORT and set MemErr.
  - Else: increment the wait counter.
- ABORT transitions: always go to RUN after one cycle. A MemReady arriving during ABORT is ignored.
- The hazard unit holds its requests stable while the pipeline is frozen, because E does not advance. A masked flush is therefore applied in the release cycle, with no extra storage.
- StallCycles increments in any cycle where EnF=0 while rst is low.
- FlushCount increments in any cycle where ClrD=1 while rst is low.
- Both counters saturate at all-ones.
- MemErr clears only on reset.

## Timing
- MemValid, the enables and the clears are combinational from the state and inputs, with no added latency. State and counters are registered.
- A zero-wait access costs 0 stall cycles. An access whose MemReady arrives N cycles after the request costs N frozen cycles.
- Abort occurs after TIMEOUT WAIT cycles. MemErr is visible on the cycle after the WAIT→ABORT edge.
- If MemReady and the timeout condition occur in the same cycle, MemReady wins and no abort happens.
- An asserted rst mid-WAIT returns the FSM to RUN immediately. No MemValid is driven while rst is high.

## Structure
- pipeline_ctrl_pkg holds the state enum typedef (RUN, WAIT, ABORT) and the reset constants for the counters.
- One sub-module, sat_counter, is parameterised by width. It has inc and clear inputs and saturates at all-ones. It is instantiated twice, for StallCycles and FlushCount.
- The wait counter is local, of width $clog2(TIMEOUT+1).

## Test plan
- Load with MemReady tied high → MemValid=1 for one cycle, all En=1, StallCycles stays 0.
- Load with MemReady arriving 3 cycles after the request → EnF..EnM=0 and ClrW=1 for exactly 3 cycles; advance in the 4th cycle; StallCycles=3.
- FlushDH=1 and FlushEH=1 during a 2-cycle freeze → ClrD=ClrE=0 while frozen, ClrD=ClrE=1 in the release cycle, FlushCount=1.
- TIMEOUT=4 and MemReady never asserted → ABORT entered after 4 WAIT cycles with MemValid=0 and ClrW=1; MemErr=1 afterwards and stays set.
- StallFH=StallDH=1 with no memory op → EnF=EnD=0, EnE=1, StallCycles increments each cycle. Preload StallCycles to 2^CNT_WIDTH−1 and verify it holds at that value.
- rst asserted in the 2nd WAIT cycle → outputs forced to reset values immediately; after release: state RUN, counters 0, MemErr 0.
